// File: rtl/cpu_pkg.sv
// Shared definitions for the Simple RISC Machine control FSM: state encoding,
// instruction field constants, output encodings and the branch-condition helper.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPDATE_PC,
    S_DECODE,
    S_MOV_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_ADDR,
    S_LOAD_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_GET_D,
    S_MOVE_D,
    S_MEM_WR,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_BRANCH = 3'b001;
  localparam logic [2:0] OPC_LDR    = 3'b011;
  localparam logic [2:0] OPC_STR    = 3'b100;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_BRANCH  = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RM   = 3'b010;
  localparam logic [2:0] NSEL_RD   = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  // Signed less-than after a CMP is N xor V; LE adds the equal case.
  function automatic logic branch_taken(input logic [2:0] cond, input logic z,
                                        input logic n, input logic v);
    logic lt;
    lt = n ^ v;
    case (cond)
      COND_AL: return 1'b1;
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_LT: return lt;
      COND_LE: return lt | z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Moore control FSM for the Simple RISC Machine: fetch, decode and per-instruction
// datapath / memory sequencing. Outputs decode purely from the state register.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       pc_sel,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  state_t r_state;
  state_t w_next_state;

  logic w_is_mov_imm, w_is_mov_reg, w_is_alu, w_is_cmp;
  logic w_is_ldr, w_is_str, w_is_branch, w_is_halt;

  assign w_is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign w_is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign w_is_alu     = (opcode == OPC_ALU);
  assign w_is_cmp     = w_is_alu && (op == OP_CMP);
  assign w_is_ldr     = (opcode == OPC_LDR) && (op == OP_MEM);
  assign w_is_str     = (opcode == OPC_STR) && (op == OP_MEM);
  assign w_is_branch  = (opcode == OPC_BRANCH) && (op == OP_BRANCH);
  assign w_is_halt    = (opcode == OPC_HALT);

  // NOTE: state is updated with <= so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next_state;
  end

  // NOTE: default assignment first keeps this block combinational (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST:       w_next_state = S_IF1;
      S_IF1:       w_next_state = S_IF2;
      S_IF2:       w_next_state = S_UPDATE_PC;
      S_UPDATE_PC: w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_is_mov_imm)                                        w_next_state = S_MOV_IMM;
        else if (w_is_mov_reg || w_is_alu || w_is_ldr || w_is_str) w_next_state = S_GET_A;
        else if (w_is_branch)                                    w_next_state = S_BRANCH;
        else if (w_is_halt)                                      w_next_state = S_HALT;
        else                                                     w_next_state = S_IF1;
      end
      S_MOV_IMM:   w_next_state = S_IF1;
      S_GET_A: begin
        if (w_is_ldr || w_is_str)          w_next_state = S_ADDR;
        else if (w_is_mov_reg || w_is_alu) w_next_state = S_GET_B;
        else                               w_next_state = S_IF1;
      end
      S_GET_B:     w_next_state = S_ALU;
      S_ALU:       w_next_state = w_is_cmp ? S_IF1 : S_WRITE_REG;
      S_WRITE_REG: w_next_state = S_IF1;
      S_ADDR:      w_next_state = S_LOAD_ADDR;
      S_LOAD_ADDR: w_next_state = w_is_str ? S_GET_D : S_MEM_RD;
      S_MEM_RD:    w_next_state = S_WB_MEM;
      S_WB_MEM:    w_next_state = S_IF1;
      S_GET_D:     w_next_state = S_MOVE_D;
      S_MOVE_D:    w_next_state = S_MEM_WR;
      S_MEM_WR:    w_next_state = S_IF1;
      S_BRANCH:    w_next_state = S_IF1;
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_RST;
    endcase
  end

  always_comb begin
    nsel      = NSEL_NONE;
    vsel      = VSEL_C;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    pc_sel    = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (r_state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPDATE_PC: load_pc = 1'b1;
      S_MOV_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        asel  = w_is_mov_reg;
        loads = w_is_cmp;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LOAD_ADDR: load_addr = 1'b1;
      S_MEM_RD:    mem_cmd = MEM_READ;
      S_WB_MEM: begin
        mem_cmd = MEM_READ;
        nsel    = NSEL_RD;
        vsel    = VSEL_MDATA;
        write   = 1'b1;
      end
      S_GET_D: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      S_MOVE_D: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_WR: mem_cmd = MEM_WRITE;
      // PC already holds PC+1 here, so pc_sel adds sximm8 on top of it.
      S_BRANCH: begin
        load_pc = branch_taken(cond, Z, N, V);
        pc_sel  = load_pc;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Moore-style control FSM for the Simple RISC Machine CPU. Sequences fetch (memory read into the instruction register, PC update), then drives the datapath and memory-interface control for the decoded instruction. Consumes the instruction decoder's `opcode`, `op` and `cond` fields plus the datapath status flags. Returns `nsel` to the decoder to select Rn/Rm/Rd.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; forces state RST.
- opcode  in  3  instruction bits [15:13] from the decoder.
- op  in  2  instruction bits [12:11].
- cond  in  3  instruction bits [10:8]; branch condition.
- Z, N, V  in  1 each  status flags: zero, negative, overflow.
- nsel  out  3  one-hot register-field select: 001 Rn, 010 Rm, 100 Rd, 000 none.
- vsel  out  2  writeback source: 00 C, 01 sximm8, 10 mdata, 11 PC.
- loada, loadb, loadc, loads  out  1  datapath register enables.
- asel  out  1  1 = ALU A-input forced to 0.
- bsel  out  1  1 = ALU B-input is sximm5.
- write  out  1  register-file write enable.
- load_ir  out  1  instruction register load.
- load_pc  out  1  PC load.
- reset_pc  out  1  PC next = 0.
- pc_sel  out  1  PC next = PC + sximm8 (0 = PC+1).
- addr_sel  out  1  memory address from PC (1) or data-address register (0).
- load_addr  out  1  data-address register load from C.
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE.
- halted  out  1  high in HALT.

## Operation
- All outputs are a pure function of the state. Anything not listed for a state is 0; nsel = 000.
- RST: reset_pc, load_pc. Next state is IF1.
- IF1: addr_sel, mem_cmd=READ. Next state is IF2.
- IF2: addr_sel, mem_cmd=READ, load_ir. Next state is UPDATE_PC.
- UPDATE_PC: load_pc (pc_sel=0). Next state is DECODE.
- DECODE: no outputs. Dispatch on {opcode, op}:
  - 110_10 (MOV imm): go to MOV_IMM.
  - 110_00 (MOV reg), 101_xx (ALU), 011_00 (LDR), 100_00 (STR): go to GET_A.
  - 001_00 (branch): go to BRANCH.
  - 111_xx: go to HALT.
  - Anything else: go to IF1 (NOP).
- MOV_IMM: nsel=Rn, vsel=01, write. Then IF1.
- GET_A: nsel=Rn, loada.
  - MOV reg: go to GET_B.
  - ALU: go to GET_B.
  - LDR/STR: go to ADDR.
- GET_B: nsel=Rm, loadb. Then ALU.
- ALU: loadc; asel=1 for MOV reg; loads only for CMP (101_01).
  - CMP: go to IF1.
  - Otherwise: go to WRITE_REG.
- WRITE_REG: nsel=Rd, vsel=00, write. Then IF1.
- ADDR: bsel, loadc (C = Rn + sximm5). Then LOAD_ADDR.
- LOAD_ADDR: load_addr.
  - LDR: go to MEM_RD.
  - STR: go to GET_D.
- MEM_RD: mem_cmd=READ, addr_sel=0. Then WB_MEM.
- WB_MEM: mem_cmd=READ, nsel=Rd, vsel=10, write. Then IF1.
- GET_D: nsel=Rd, loadb. Then MOVE_D.
- MOVE_D: asel, loadc. Then MEM_WR.
- MEM_WR: mem_cmd=WRITE, addr_sel=0. Then IF1.
- BRANCH: taken condition by cond:
  - 000: always taken.
  - 001: taken if Z.
  - 010: taken if !Z.
  - 011: taken if N≠V.
  - 100: taken if (N≠V)|Z.
  - Others: never taken.
  - When taken: load_pc=1, pc_sel=1. PC already holds PC+1, so target = PC+1+sximm8. Next state is IF1.
- HALT: halted=1. Stays in HALT until reset.

## Timing
- One state per cycle. Outputs change only on the clk edge that changes the state.
- Reset outputs: state RST, so reset_pc=1, load_pc=1, all other outputs 0, nsel=000.
- Reset wins over every transition, including mid-instruction and in HALT. The next edge after reset deasserts enters IF1.
- Memory read data is valid in the cycle after a READ command is issued. IF2 and WB_MEM therefore keep mem_cmd=READ while sampling.
- Cycles from IF1 to the next IF1:
  - MOV imm: 5.
  - MOV reg, ALU: 8.
  - CMP: 7.
  - LDR: 9.
  - STR: 10.
  - Branch: 5.
  - NOP: 4.
- Flags are sampled in BRANCH. They reflect the last loads; a CMP two instructions earlier is visible.

## Structure
- Shared package cpu_pkg holds:
  - state enum;
  - opcode and op constants;
  - mem_cmd encodings (NONE/READ/WRITE);
  - nsel one-hot constants (NSEL_RN/RM/RD);
  - vsel encodings;
  - cond encodings.
- No sub-module. Branch-condition evaluation is a package function, branch_taken(cond, Z, N, V).

## Test plan
- Reset held 2 cycles, then released. Required: reset_pc=load_pc=1 during reset, then IF1, IF2 (load_ir=1), UPDATE_PC (load_pc=1) in order.
- Apply opcode=110, op=10 at DECODE. Required: next cycle nsel=001, vsel=01, write=1, then IF1. Repeat with opcode=101, op=01 (CMP): loads=1 in ALU, write never asserted.
- Apply LDR (011_00). Required: GET_A, ADDR (bsel=1), LOAD_ADDR, MEM_RD (mem_cmd=01, addr_sel=0), WB_MEM (vsel=10, nsel=100, write=1). Repeat with STR (100_00): mem_cmd=10 in MEM_WR.
- Branch with cond=001:
  - Z=1: load_pc=1 and pc_sel=1 in BRANCH.
  - Z=0: load_pc=0.
  - cond=100 with N=1, V=0, Z=0: taken.
  - cond=111: never taken.
- Apply HALT (111). Required: halted=1 held for 20 cycles. Then pulse reset: state RST next edge, halted=0.
- Assert reset in MEM_WR and in GET_B. Required: next state RST, mem_cmd=00 and write=0 in that cycle.
